ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 160 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: 32-cycle shift-add multiply
// and restoring divide on magnitudes, with a one-cycle path for divide-by-zero and overflow.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exMD,
  input  logic [2:0]  exfunct3,
  input  logic [31:0] exOperand1,
  input  logic [31:0] exOperand2,
  input  logic [4:0]  exRegDes,
  input  logic        flush,
  output logic        mdStall,
  output logic        mdDone,
  output logic [31:0] mdResult,
  output logic [4:0]  mdRegDes
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg;
  logic [63:0] acc_reg;
  logic [31:0] opnd_reg;
  logic [2:0]  f3_reg;
  logic [4:0]  rd_reg;
  logic        neg_reg;
  logic        rneg_reg;
  logic [31:0] md_result_reg;
  logic [4:0]  md_regdes_reg;

  // Operand decode on the incoming instruction
  logic        is_div, op1_signed, op2_signed, s1, s2;
  logic [31:0] mag1, mag2;
  logic        div_zero, div_ovf, fast, start;
  logic [31:0] fast_val;

  always_comb begin
    is_div     = exfunct3[2];
    op1_signed = is_div ? ~exfunct3[0] : (exfunct3[1:0] != 2'b11);
    op2_signed = is_div ? ~exfunct3[0] : (exfunct3[1] == 1'b0);
    s1         = op1_signed & exOperand1[31];
    s2         = op2_signed & exOperand2[31];
    mag1       = s1 ? (32'd0 - exOperand1) : exOperand1;
    mag2       = s2 ? (32'd0 - exOperand2) : exOperand2;
    div_zero   = is_div && (exOperand2 == 32'd0);
    div_ovf    = is_div && !exfunct3[0] && (exOperand1 == 32'h8000_0000)
                 && (exOperand2 == 32'hFFFF_FFFF);
    fast       = div_zero | div_ovf;
    if (div_zero)
      fast_val = exfunct3[1] ? exOperand1 : 32'hFFFF_FFFF;
    else
      fast_val = exfunct3[1] ? 32'd0 : 32'h8000_0000;
    start      = (state_reg == IDLE) && exMD && !flush;
  end

  // One iteration step: acc holds {hi, lo} = {partial product, multiplier}
  // for multiply, {remainder, dividend/quotient} for divide.
  logic [32:0] mul_sum, div_shift, div_diff;
  logic        div_ge;
  logic [63:0] acc_next;
  logic [63:0] prod_signed;
  logic [31:0] quot, rem, final_val;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    div_shift = {acc_reg[63:32], acc_reg[31]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    div_ge    = ~div_diff[32];
    if (f3_reg[2])
      acc_next = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc_reg[30:0], div_ge};
    else
      acc_next = {mul_sum, acc_reg[31:1]};

    prod_signed = neg_reg ? (64'd0 - acc_next) : acc_next;
    quot        = neg_reg ? (32'd0 - acc_next[31:0]) : acc_next[31:0];
    rem         = rneg_reg ? (32'd0 - acc_next[63:32]) : acc_next[63:32];
    if (f3_reg[2])
      final_val = f3_reg[1] ? rem : quot;
    else
      final_val = (f3_reg[1:0] == 2'b00) ? prod_signed[31:0] : prod_signed[63:32];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mdStall    = 1'b0;
    mdDone     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start)
          state_next = fast ? DONE : CALC;
      end
      CALC: begin
        if (cnt_reg == 6'd31)
          state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
        mdDone     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (flush)
      state_next = IDLE;
    mdStall = rst_n && (start || (state_reg == CALC));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg       <= 6'd0;
      acc_reg       <= 64'd0;
      opnd_reg      <= 32'd0;
      f3_reg        <= 3'd0;
      rd_reg        <= 5'd0;
      neg_reg       <= 1'b0;
      rneg_reg      <= 1'b0;
      md_result_reg <= 32'd0;
      md_regdes_reg <= 5'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cnt_reg  <= 6'd0;
            acc_reg  <= {32'd0, (is_div ? mag1 : mag2)};
            opnd_reg <= is_div ? mag2 : mag1;
            f3_reg   <= exfunct3;
            rd_reg   <= exRegDes;
            neg_reg  <= s1 ^ s2;
            rneg_reg <= s1;
            if (fast) begin
              md_result_reg <= fast_val;
              md_regdes_reg <= exRegDes;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + 6'd1;
            if (cnt_reg == 6'd31) begin
              md_result_reg <= final_val;
              md_regdes_reg <= rd_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mdResult = md_result_reg;
  assign mdRegDes = md_regdes_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, results, fast paths, flush and reset behaviour.
module tb_ex_muldiv;

  logic        clk;
  logic        rst_n;
  logic        exMD;
  logic [2:0]  exfunct3;
  logic [31:0] exOperand1;
  logic [31:0] exOperand2;
  logic [4:0]  exRegDes;
  logic        flush;
  logic        mdStall;
  logic        mdDone;
  logic [31:0] mdResult;
  logic [4:0]  mdRegDes;

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .exMD       (exMD),
    .exfunct3   (exfunct3),
    .exOperand1 (exOperand1),
    .exOperand2 (exOperand2),
    .exRegDes   (exRegDes),
    .flush      (flush),
    .mdStall    (mdStall),
    .mdDone     (mdDone),
    .mdResult   (mdResult),
    .mdRegDes   (mdRegDes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Present an op for one cycle (start cycle T), then drop exMD in T+1.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    @(posedge clk); #1;
    exMD = 1'b1; exfunct3 = f3; exOperand1 = a; exOperand2 = b; exRegDes = rd;
    #1;
    check("start_stall", mdStall, 1);
    @(posedge clk); #1;
    exMD = 1'b0;
  endtask

  // Called in cycle T+1; exp_lat is the cycle offset from T at which mdDone is expected.
  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res,
                           input logic [4:0] exp_rd);
    int lat;
    bit stall_ok;
    lat = 0;
    stall_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (mdDone) begin
        lat = c;
        break;
      end
      if (!mdStall) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, mdResult, exp_res);
    check({tag, "_rd"}, mdRegDes, exp_rd);
    check({tag, "_donestall"}, mdStall, 0);
    if (exp_lat > 1) check({tag, "_calcstall"}, stall_ok, 1);
    @(posedge clk); #1;
    check({tag, "_doneclr"}, mdDone, 0);
    check({tag, "_hold"}, mdResult, exp_res);
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0; exMD = 1'b1; exfunct3 = 3'd0; exOperand1 = 32'd7;
    exOperand2 = 32'd3; exRegDes = 5'd9; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", mdStall, 0);
    check("rst_done", mdDone, 0);
    check("rst_result", mdResult, 0);
    check("rst_regdes", mdRegDes, 0);
    exMD = 1'b0;
    rst_n = 1'b1;

    start_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    wait_done("mul", 33, 32'hFFFF_FFEB, 5'd5);
    start_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6);
    wait_done("mulh", 33, 32'h4000_0000, 5'd6);
    start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    wait_done("mulhu", 33, 32'hFFFF_FFFE, 5'd7);
    start_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8);
    wait_done("mulhsu", 33, 32'hFFFF_FFFF, 5'd8);
    start_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10);
    wait_done("div", 33, 32'hFFFF_FFFD, 5'd10);
    start_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11);
    wait_done("rem", 33, 32'hFFFF_FFFF, 5'd11);
    start_op(3'b101, 32'd100, 32'd7, 5'd12);
    wait_done("divu", 33, 32'd14, 5'd12);
    start_op(3'b111, 32'd100, 32'd7, 5'd13);
    wait_done("remu", 33, 32'd2, 5'd13);
    start_op(3'b101, 32'd55, 32'd0, 5'd14);
    wait_done("divu0", 1, 32'hFFFF_FFFF, 5'd14);
    start_op(3'b111, 32'h1234, 32'd0, 5'd15);
    wait_done("remu0", 1, 32'h1234, 5'd15);
    start_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    wait_done("divovf", 1, 32'h8000_0000, 5'd16);
    start_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
    wait_done("removf", 1, 32'd0, 5'd17);

    // Flush in cycle T+10 of a DIV; last result (0) must hold, no mdDone.
    start_op(3'b100, 32'd1000, 32'd3, 5'd18);
    saw_done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (mdDone) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_nodone", saw_done | mdDone, 0);
    check("flush_idle_stall", mdStall, 0);
    check("flush_hold", mdResult, 0);
    start_op(3'b000, 32'd6, 32'd7, 5'd19);
    wait_done("mul_after_flush", 33, 32'd42, 5'd19);

    // Reset at T+5 of a MUL with exMD held high, then restart once released.
    @(posedge clk); #1;
    exMD = 1'b1; exfunct3 = 3'b000; exOperand1 = 32'd7;
    exOperand2 = 32'hFFFF_FFFD; exRegDes = 5'd5;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_stall", mdStall, 0);
    @(posedge clk); #1;
    check("rstmid_done", mdDone, 0);
    check("rstmid_result", mdResult, 0);
    check("rstmid_regdes", mdRegDes, 0);
    rst_n = 1'b1;
    #1;
    check("restart_stall", mdStall, 1);
    @(posedge clk); #1;
    exMD = 1'b0;
    wait_done("mul_restart", 33, 32'hFFFF_FFEB, 5'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
